// File: rtl/sprite_bg_compositor.sv
// Purpose: merges the delay-aligned sprite layer with the background layer into the game-window RGB and gathers per-frame collision statistics.
// Latency: background/position -> vgaRgbOut 1 cycle; sprite inputs -> vgaRgbOut BG_DELAY+1 cycles; status updates on frameStart edges.
// Backpressure: none; this is a free-running pixel-rate stage that accepts one pixel every clock.
//
// Ports: clk/rst (sync, active-high); scan position, window and frame pulse aligned with bgRgbIn;
//        sprite valid/colour/priority arriving BG_DELAY cycles early; vgaRgbOut registered mix;
//        hitFlag/hitCount/hitPosX/hitPosY hold the last completed frame's collision summary.
// Optional: define SPRITE_BG_COMPOSITOR_HITMARK_EN to paint colliding pixels with HIT_COLOUR.
module sprite_bg_compositor #(
    parameter int                 RGB_BIT    = 12,
    parameter int                 POS_BIT    = 10,
    parameter int                 BG_DELAY   = 2,
    parameter logic [RGB_BIT-1:0] TRANS_KEY  = 12'h000,
    parameter logic [RGB_BIT-1:0] BACKDROP   = 12'h000,
    parameter logic [RGB_BIT-1:0] HIT_COLOUR = 12'hF0F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [POS_BIT-1:0] vgaPosX,
    input  logic [POS_BIT-1:0] vgaPosY,
    input  logic               IsGameWindow,
    input  logic               frameStart,
    input  logic               spriteValid,
    input  logic [RGB_BIT-1:0] spriteRgbIn,
    input  logic               spriteBehind,
    input  logic [RGB_BIT-1:0] bgRgbIn,
    output logic [RGB_BIT-1:0] vgaRgbOut,
    output logic               hitFlag,
    output logic [7:0]         hitCount,
    output logic [POS_BIT-1:0] hitPosX,
    output logic [POS_BIT-1:0] hitPosY
);

`ifdef SPRITE_BG_COMPOSITOR_HITMARK_EN
    localparam bit MARK_EN = 1'b1;
`else
    localparam bit MARK_EN = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Sprite layer after alignment with the background pipeline.
    logic               spr_vld;
    logic [RGB_BIT-1:0] spr_rgb;
    logic               spr_behind;

    generate
        if (BG_DELAY == 0) begin : g_bypass
            assign spr_vld    = spriteValid;
            assign spr_rgb    = spriteRgbIn;
            assign spr_behind = spriteBehind;
        end else begin : g_delay
            logic [BG_DELAY-1:0] vld_sr;
            logic [BG_DELAY-1:0] beh_sr;
            logic [RGB_BIT-1:0]  rgb_sr [BG_DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                    beh_sr <= '0;
                    for (int i = 0; i < BG_DELAY; i++) rgb_sr[i] <= '0;
                end else begin
                    vld_sr[0] <= spriteValid;
                    beh_sr[0] <= spriteBehind;
                    rgb_sr[0] <= spriteRgbIn;
                    for (int i = 1; i < BG_DELAY; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                        beh_sr[i] <= beh_sr[i-1];
                        rgb_sr[i] <= rgb_sr[i-1];
                    end
                end
            end

            assign spr_vld    = vld_sr[BG_DELAY-1];
            assign spr_behind = beh_sr[BG_DELAY-1];
            assign spr_rgb    = rgb_sr[BG_DELAY-1];
        end
    endgenerate

    // Mix stage: opacity, priority and collision detection on the aligned pixel.
    logic               spr_op;
    logic               bg_op;
    logic               evt;
    logic [RGB_BIT-1:0] mix_rgb;

    assign spr_op = spr_vld && (spr_rgb != TRANS_KEY);
    assign bg_op  = (bgRgbIn != TRANS_KEY);
    // Collision ignores the priority bit: a hidden sprite still overlaps the background.
    assign evt    = IsGameWindow && spr_op && bg_op;

    always_comb begin
        mix_rgb = BACKDROP;
        if (!IsGameWindow)
            mix_rgb = '0;
        else if (MARK_EN && evt)
            mix_rgb = HIT_COLOUR;
        else if (spr_op && (!spr_behind || !bg_op))
            mix_rgb = spr_rgb;
        else if (bg_op)
            mix_rgb = bgRgbIn;
    end

    always_ff @(posedge clk) begin
        if (rst) vgaRgbOut <= '0;
        else     vgaRgbOut <= mix_rgb;
    end

    // Frame statistics: working set accumulates, frameStart publishes and restarts it.
    state_t             state;
    logic               w_flag;
    logic [7:0]         w_count;
    logic [POS_BIT-1:0] w_x;
    logic [POS_BIT-1:0] w_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            w_flag   <= 1'b0;
            w_count  <= '0;
            w_x      <= '0;
            w_y      <= '0;
            hitFlag  <= 1'b0;
            hitCount <= '0;
            hitPosX  <= '0;
            hitPosY  <= '0;
        end else if (frameStart) begin
            // The frameStart pixel belongs to the new frame, so an event here seeds it.
            state    <= ST_ACTIVE;
            hitFlag  <= w_flag;
            hitCount <= w_count;
            hitPosX  <= w_x;
            hitPosY  <= w_y;
            w_flag   <= evt;
            w_count  <= evt ? 8'd1 : 8'd0;
            w_x      <= evt ? vgaPosX : '0;
            w_y      <= evt ? vgaPosY : '0;
        end else if (state == ST_ACTIVE && evt) begin
            w_flag <= 1'b1;
            if (w_count != 8'hFF) w_count <= w_count + 8'd1;
            if (!w_flag) begin
                w_x <= vgaPosX;
                w_y <= vgaPosY;
            end
        end
    end

endmodule

// File: tb/tb_sprite_bg_compositor.sv
// Purpose: randomized and directed check of sprite_bg_compositor against a frame-level reference model.
// Latency: compares every output one cycle after each set of inputs is applied.
// Backpressure: none; inputs are driven every cycle.
module tb_sprite_bg_compositor;
    localparam int D     = 2;
    localparam int MAXC  = 8192;
    localparam logic [11:0] TK = 12'h000;
    localparam logic [11:0] BD = 12'h000;
    localparam logic [11:0] HC = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  vgaPosX, vgaPosY;
    logic        IsGameWindow, frameStart, spriteValid, spriteBehind;
    logic [11:0] spriteRgbIn, bgRgbIn, vgaRgbOut;
    logic        hitFlag;
    logic [7:0]  hitCount;
    logic [9:0]  hitPosX, hitPosY;

    sprite_bg_compositor #(.RGB_BIT(12), .POS_BIT(10), .BG_DELAY(D),
                           .TRANS_KEY(TK), .BACKDROP(BD), .HIT_COLOUR(HC)) dut (
        .clk(clk), .rst(rst), .vgaPosX(vgaPosX), .vgaPosY(vgaPosY),
        .IsGameWindow(IsGameWindow), .frameStart(frameStart),
        .spriteValid(spriteValid), .spriteRgbIn(spriteRgbIn), .spriteBehind(spriteBehind),
        .bgRgbIn(bgRgbIn), .vgaRgbOut(vgaRgbOut), .hitFlag(hitFlag), .hitCount(hitCount),
        .hitPosX(hitPosX), .hitPosY(hitPosY));

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Input history, one entry per clock edge.
    logic        h_rst [MAXC];
    logic        h_fs  [MAXC];
    logic        h_gw  [MAXC];
    logic        h_sv  [MAXC];
    logic        h_sb  [MAXC];
    logic [11:0] h_srgb[MAXC];
    logic [11:0] h_bg  [MAXC];
    logic [9:0]  h_x   [MAXC];
    logic [9:0]  h_y   [MAXC];

    // Reference state: frame hit tally kept as a plain integer, clamped only when published.
    logic        m_active = 1'b0;
    int          m_hits   = 0;
    logic [9:0]  m_fx = '0, m_fy = '0;
    logic [11:0] exp_rgb = '0;
    logic        p_flag = 1'b0;
    int          p_cnt = 0;
    logic [9:0]  p_x = '0, p_y = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update(input int n);
        int          m;
        logic        sv_a, sb_a, sop, bop, evt;
        logic [11:0] srgb_a;
        if (h_rst[n]) begin
            exp_rgb = '0; m_active = 1'b0; m_hits = 0; m_fx = '0; m_fy = '0;
            p_flag = 1'b0; p_cnt = 0; p_x = '0; p_y = '0;
            return;
        end
        m = n - D;
        sv_a = 1'b0; sb_a = 1'b0; srgb_a = '0;
        if (m >= 0) begin
            sv_a = h_sv[m]; sb_a = h_sb[m]; srgb_a = h_srgb[m];
            // A reset on any edge the sprite spent in the delay line drops it.
            for (int k = m; k < n; k++) if (h_rst[k]) sv_a = 1'b0;
        end
        sop = sv_a && (srgb_a != TK);
        bop = (h_bg[n] != TK);
        evt = h_gw[n] && sop && bop;
        if (!h_gw[n])                  exp_rgb = '0;
`ifdef SPRITE_BG_COMPOSITOR_HITMARK_EN
        else if (evt)                  exp_rgb = HC;
`endif
        else if (sop && (!sb_a || !bop)) exp_rgb = srgb_a;
        else if (bop)                  exp_rgb = h_bg[n];
        else                           exp_rgb = BD;
        if (h_fs[n]) begin
            p_flag = (m_hits > 0);
            p_cnt  = (m_hits > 255) ? 255 : m_hits;
            p_x = m_fx; p_y = m_fy;
            m_active = 1'b1;
            m_hits = evt ? 1 : 0;
            m_fx = evt ? h_x[n] : '0;
            m_fy = evt ? h_y[n] : '0;
        end else if (m_active && evt) begin
            if (m_hits == 0) begin m_fx = h_x[n]; m_fy = h_y[n]; end
            m_hits++;
        end
    endtask

    task automatic step(input logic r, input logic f, input logic g, input logic v,
                        input logic [11:0] s, input logic b, input logic [11:0] bgc,
                        input logic [9:0] x, input logic [9:0] y);
        rst = r; frameStart = f; IsGameWindow = g; spriteValid = v;
        spriteRgbIn = s; spriteBehind = b; bgRgbIn = bgc; vgaPosX = x; vgaPosY = y;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget got=%0d exp<%0d", cyc, MAXC);
            $fatal(1, "history overflow");
        end
        h_rst[cyc] = r; h_fs[cyc] = f; h_gw[cyc] = g; h_sv[cyc] = v; h_srgb[cyc] = s;
        h_sb[cyc] = b; h_bg[cyc] = bgc; h_x[cyc] = x; h_y[cyc] = y;
        @(posedge clk); #1;
        model_update(cyc);
        cyc++;
        chk("rgb",  32'(vgaRgbOut), 32'(exp_rgb));
        chk("flag", 32'(hitFlag),   32'(p_flag));
        chk("cnt",  32'(hitCount),  32'(p_cnt));
        chk("px",   32'(hitPosX),   32'(p_x));
        chk("py",   32'(hitPosY),   32'(p_y));
    endtask

    // One sprite pixel issued D cycles ahead of its background; returns the composited colour.
    task automatic spr_px(input logic f_last, input logic g, input logic b, input logic [11:0] s,
                          input logic [11:0] bgc, input logic [9:0] x, input logic [9:0] y,
                          output logic [11:0] seen);
        step(0, 0, g, 1, s, b, bgc, x, y);
        step(0, 0, g, 0, 12'h000, 0, bgc, x, y);
        step(0, f_last, g, 0, 12'h000, 0, bgc, x, y);
        seen = vgaRgbOut;
    endtask

    logic [11:0] seen;
    logic [11:0] exp_mark;
    int          flen, fpos;
    logic [9:0]  rx, ry;

    initial begin
`ifdef SPRITE_BG_COMPOSITOR_HITMARK_EN
        exp_mark = HC;
`else
        exp_mark = 12'hF00;
`endif
        // Reset state.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 12'h5A5, 0, 12'h333, 10'd1, 10'd1);
        chk("reset_rgb", 32'(vgaRgbOut), 32'h0);
        chk("reset_cnt", 32'(hitCount), 32'h0);

        // Latency: sprite D+1 cycles, background 1 cycle.
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        step(0, 0, 1, 1, 12'hABC, 0, 12'h000, 10'd1, 10'd0);
        step(0, 0, 1, 0, 12'h000, 0, 12'h000, 10'd2, 10'd0);
        chk("lat_early", 32'(vgaRgbOut), 32'h0);
        step(0, 0, 1, 0, 12'h000, 0, 12'h000, 10'd3, 10'd0);
        chk("lat_sprite", 32'(vgaRgbOut), 32'hABC);
        step(0, 0, 1, 0, 12'h000, 0, 12'h123, 10'd4, 10'd0);
        chk("lat_bg", 32'(vgaRgbOut), 32'h123);

        // Priority and window gating; both priority cases are collisions.
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd1);
        spr_px(0, 1, 0, 12'hF00, 12'h0F0, 10'd20, 10'd7, seen);
        chk("prio_front", 32'(seen), 32'(exp_mark));
        spr_px(0, 1, 1, 12'hF00, 12'h0F0, 10'd21, 10'd7, seen);
`ifdef SPRITE_BG_COMPOSITOR_HITMARK_EN
        chk("prio_behind", 32'(seen), 32'hF0F);
`else
        chk("prio_behind", 32'(seen), 32'h0F0);
`endif
        spr_px(0, 0, 0, 12'hF00, 12'h0F0, 10'd22, 10'd7, seen);
        chk("win_off", 32'(seen), 32'h0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        chk("prio_cnt", 32'(hitCount), 32'd2);
        chk("prio_pos", 32'({hitPosX, hitPosY}), 32'({10'd20, 10'd7}));

        // Mid-frame reset discards the frame; IDLE ignores events until frameStart.
        spr_px(0, 1, 0, 12'h00F, 12'h0F0, 10'd30, 10'd2, seen);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 12'h00F, 0, 12'h0F0, 10'd31, 10'd2);
        chk("rst_rgb", 32'(vgaRgbOut), 32'h0);
        chk("rst_flag", 32'(hitFlag), 32'h0);
        spr_px(0, 1, 0, 12'h00F, 12'h0F0, 10'd32, 10'd2, seen);
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        chk("rst_pub_cnt", 32'(hitCount), 32'h0);

        // 300 collisions in one frame, first at (37,12): count saturates.
        for (int k = 0; k < 302; k++)
            step(0, 0, 1, (k < 300), 12'h777, k[0], 12'h444,
                 (k == 2) ? 10'd37 : 10'(100 + k), (k == 2) ? 10'd12 : 10'd13);
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        chk("sat_flag", 32'(hitFlag), 32'h1);
        chk("sat_cnt", 32'(hitCount), 32'd255);
        chk("sat_pos", 32'({hitPosX, hitPosY}), 32'({10'd37, 10'd12}));

        // Four hits, then frameStart coinciding with a hit at (5,0).
        for (int i = 0; i < 4; i++) spr_px(0, 1, 0, 12'hF00, 12'h0F0, 10'(50 + i), 10'd3, seen);
        spr_px(1, 1, 0, 12'hF00, 12'h0F0, 10'd5, 10'd0, seen);
        chk("coin_cnt", 32'(hitCount), 32'd4);
        chk("coin_rgb", 32'(seen), 32'(exp_mark));
        step(0, 0, 1, 0, 12'h000, 0, 12'h000, 10'd6, 10'd0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        chk("coin_next_cnt", 32'(hitCount), 32'd1);
        chk("coin_next_pos", 32'({hitPosX, hitPosY}), 32'({10'd5, 10'd0}));

        // Back-to-back frameStart publishes an empty frame.
        spr_px(0, 1, 0, 12'hF00, 12'h0F0, 10'd9, 10'd9, seen);
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        step(0, 1, 1, 0, 12'h000, 0, 12'h000, 10'd0, 10'd0);
        chk("b2b_flag", 32'(hitFlag), 32'h0);
        chk("b2b_cnt", 32'(hitCount), 32'h0);

        // Randomized frames with occasional resets and back-to-back pulses.
        flen = 30; fpos = 0; rx = '0; ry = '0;
        for (int i = 0; i < 1500; i++) begin
            logic r, f, g, v, b;
            logic [11:0] s, bgc;
            r = ($urandom_range(0, 399) == 0);
            f = (fpos == 0) || ($urandom_range(0, 199) == 0);
            g = ($urandom_range(0, 6) != 0);
            v = $urandom_range(0, 1);
            b = $urandom_range(0, 1);
            s   = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            bgc = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            if (f) begin rx = '0; ry = '0; end
            step(r, f, g, v, s, b, bgc, rx, ry);
            rx = rx + 10'd1;
            if (rx == 10'd16) begin rx = '0; ry = ry + 10'd1; end
            fpos++;
            if (fpos >= flen) begin fpos = 0; flen = $urandom_range(20, 60); end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_bg_compositor.md
Name: sprite_bg_compositor

Overview:
Downstream stage of the sprite draw path. Merges the per-pixel sprite colour from the sprite draw top level with the background tile colour and produces the final game-window RGB for the VGA driver. Aligns sprite data to the background pipeline latency and applies transparency and priority rules. Gathers per-frame sprite/background collision statistics, which it presents to software as frame-stable status.

Parameters:
RGB_BIT, 12, colour width (matches `RGB_BIT)
POS_BIT, 10, VGA coordinate width (matches `VGA_POSXY_BIT)
BG_DELAY, 2, cycles the sprite path is delayed to align with background; legal range 0..7
TRANS_KEY, 12'h000, colour code treated as transparent on either input
BACKDROP, 12'h000, output colour when both layers are transparent
HIT_COLOUR, 12'hF0F, marker colour for the optional feature

Ports:
clk  in  1  pixel-rate clock (clk_25p2MHz domain)
rst  in  1  synchronous reset, active-high
vgaPosX  in  POS_BIT  current scan X, aligned with background input
vgaPosY  in  POS_BIT  current scan Y, aligned with background input
IsGameWindow  in  1  current pixel lies inside the game area, aligned with background input
frameStart  in  1  one-cycle pulse on the first pixel of each frame
spriteValid  in  1  sprite layer hit at this pixel, unaligned (BG_DELAY early)
spriteRgbIn  in  RGB_BIT  sprite colour, unaligned
spriteBehind  in  1  sprite priority bit: 1 = draw behind opaque background, unaligned
bgRgbIn  in  RGB_BIT  background colour, aligned
vgaRgbOut  out  RGB_BIT  composited colour, registered
hitFlag  out  1  last completed frame had at least one collision
hitCount  out  8  collisions in last completed frame, saturating
hitPosX  out  POS_BIT  X of first collision in last completed frame
hitPosY  out  POS_BIT  Y of first collision in last completed frame

Behaviour:
- Reset (rst=1 at posedge): all outputs, delay-line stages and working counters go to 0. Mid-frame reset discards the in-progress frame. Outputs stay 0 until after the next frameStart.
- Sprite alignment: spriteValid, spriteRgbIn and spriteBehind pass through a BG_DELAY-deep shift register. When BG_DELAY=0 the registers are bypassed. Reset clears every stage to valid=0.
- Opacity:
  - sOp = aligned spriteValid && aligned spriteRgb != TRANS_KEY
  - bOp = bgRgbIn != TRANS_KEY
- Mix, registered one cycle:
  - IsGameWindow=0 -> 0
  - else sOp && (!behind || !bOp) -> sprite colour
  - else bOp -> bgRgbIn
  - else BACKDROP
- Latency: background/position -> vgaRgbOut is 1 cycle. Sprite input -> vgaRgbOut is BG_DELAY+1 cycles.
- Collision event: IsGameWindow && sOp && bOp, evaluated at the mix stage. The event is independent of the behind bit.
- Working registers: wFlag, wCount (8-bit, saturates at 255, never wraps), wX, wY. wX/wY latch only on the first event of a frame (wFlag 0 -> 1).
- Two-state frame FSM:
  - IDLE: after reset, events are ignored. On frameStart go to ACTIVE.
  - ACTIVE: events accumulate. On each frameStart, wFlag/wCount/wX/wY are copied to hitFlag/hitCount/hitPosX/hitPosY on the same edge, then the working registers clear.
- Simultaneous frameStart and event: the report receives the old frame's values. The new event becomes the first event of the new frame (wCount=1, wFlag=1, wX/wY = current position).
- Back-to-back frameStart (two consecutive cycles): the second pulse publishes an empty frame (flag 0, count 0, pos 0).
- Status outputs change only on frameStart edges and are stable for a whole frame.

Optional Feature:
SPRITE_BG_COMPOSITOR_HITMARK_EN
- Defined: any pixel raising a collision event outputs HIT_COLOUR instead of the mix result. Collision counting is unchanged.
- Undefined: normal mix only; HIT_COLOUR is unused.

Test Plan:
- Reset held 3 cycles mid-frame with valid inputs -> vgaRgbOut=0 and all hit outputs 0. The next frameStart publishes hitCount=0.
- BG_DELAY=2, sprite 12'hABC valid at cycle t, bg 12'h000, IsGameWindow=1 -> vgaRgbOut=12'hABC at t+3. Background 12'h123 applied at t+2 appears at t+3.
- Sprite 12'hF00 with bg 12'h0F0: behind=0 -> output 12'hF00; behind=1 -> output 12'h0F0. Both cases increment wCount.
- Sprite valid and opaque with IsGameWindow=0 -> output 0, no collision counted.
- 300 collision pixels in one frame, first at (37,12) -> after next frameStart: hitFlag=1, hitCount=255, hitPosX=37, hitPosY=12.
- frameStart coincident with a collision at (5,0) after a frame of 4 hits -> published hitCount=4. The following frameStart publishes hitCount≥1 with position (5,0). With HITMARK_EN, that pixel outputs 12'hF0F.
